// File: rtl/wam_key_pkg.sv
// Shared definitions for the whack-a-mole key path: off-grid marker, FSM states
// and key-code field extraction used by the decoder and the grid/display logic.
package wam_key_pkg;

    // Wide all-ones value; users slice it to their hole-number width.
    localparam logic [31:0] INVALID_KEY = '1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } key_state_t;

    function automatic int unsigned key_row(input logic [31:0] code,
                                            input int row_bits,
                                            input int col_bits);
        return (code >> col_bits) & ((32'd1 << row_bits) - 32'd1);
    endfunction

    function automatic int unsigned key_col(input logic [31:0] code,
                                            input int col_bits);
        return code & ((32'd1 << col_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Hit-event handshake between the key decoder (master) and the game controller (slave).
interface key_event_decoder_if #(
    parameter int NUM_W = 4
);
    logic             hit_valid;
    logic [NUM_W-1:0] hit_number;
    logic             hit_ack;

    modport master (output hit_valid, output hit_number, input hit_ack);
    modport slave  (input hit_valid, input hit_number, output hit_ack);
endinterface

// File: rtl/key_code_map.sv
// Combinational row/column key code to linear hole number (row*COLS+col),
// with an on-grid flag; off-grid codes map to all ones.
module key_code_map
    import wam_key_pkg::*;
#(
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 2,
    parameter int ROWS     = 3,
    parameter int COLS     = 3,
    parameter int NUM_W    = 4
) (
    input  logic [ROW_BITS+COL_BITS-1:0] code,
    output logic [NUM_W-1:0]             number,
    output logic                         valid
);
    int unsigned row;
    int unsigned col;

    always_comb begin
        row    = key_row(32'(code), ROW_BITS, COL_BITS);
        col    = key_col(32'(code), COL_BITS);
        valid  = (row < ROWS) && (col < COLS);
        number = valid ? NUM_W'(row * COLS + col) : INVALID_KEY[NUM_W-1:0];
    end
endmodule

// File: rtl/key_event_decoder.sv
// Debounced key-event decoder: synchronises the raw key, debounces press and
// release, and turns each qualified press into one held hit event.
module key_event_decoder
    import wam_key_pkg::*;
#(
    parameter int ROW_BITS        = 2,
    parameter int COL_BITS        = 2,
    parameter int ROWS            = 3,
    parameter int COLS            = 3,
    parameter int NUM_W           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [ROW_BITS+COL_BITS-1:0] key,
    input  logic                         key_down,
    key_event_decoder_if.master          hit_if,
    output logic [NUM_W-1:0]             key_number,
    output logic                         invalid_pulse,
    output logic                         missed_pulse
);
    localparam int KEY_W = ROW_BITS + COL_BITS;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_W-1:0] INV_NUM  = INVALID_KEY[NUM_W-1:0];

    logic [KEY_W-1:0] key_p0, key_p1;
    logic             down_p0, down_p1;

    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [KEY_W-1:0] code, code_nxt;

    logic [NUM_W-1:0] map_number;
    logic             map_valid;
    logic             ev, take_hit, miss_ev, inval_ev;

    logic             hit_valid_r;
    logic [NUM_W-1:0] hit_number_r;

    // Stage p0/p1: two-flop synchroniser for the asynchronous key inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            key_p0  <= '0;
            key_p1  <= '0;
            down_p0 <= 1'b0;
            down_p1 <= 1'b0;
        end else begin
            key_p0  <= key;
            key_p1  <= key_p0;
            down_p0 <= key_down;
            down_p1 <= down_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            code  <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            code  <= code_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        code_nxt  = code;
        if (!enable) begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: if (down_p1) begin
                    state_nxt = ST_PRESS_DB;
                    code_nxt  = key_p1;
                    count_nxt = '0;
                end
                ST_PRESS_DB: if (!down_p1 || key_p1 != code) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end else if (count == CNT_LAST) begin
                    state_nxt = ST_HELD;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
                ST_HELD: if (!down_p1) begin
                    state_nxt = ST_RELEASE_DB;
                    count_nxt = '0;
                end
                ST_RELEASE_DB: if (down_p1) begin
                    state_nxt = ST_HELD;
                    count_nxt = '0;
                end else if (count == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
                default: begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    key_code_map #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .ROWS     (ROWS),
        .COLS     (COLS),
        .NUM_W    (NUM_W)
    ) u_map (
        .code   (code),
        .number (map_number),
        .valid  (map_valid)
    );

    // A same-cycle ack frees the slot, so the new event may replace the pending one.
    always_comb begin
        ev       = enable && (state == ST_PRESS_DB) && down_p1 &&
                   (key_p1 == code) && (count == CNT_LAST);
        take_hit = ev && map_valid && (!hit_valid_r || hit_if.hit_ack);
        miss_ev  = ev && map_valid && hit_valid_r && !hit_if.hit_ack;
        inval_ev = ev && !map_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_valid_r   <= 1'b0;
            hit_number_r  <= INV_NUM;
            key_number    <= INV_NUM;
            invalid_pulse <= 1'b0;
            missed_pulse  <= 1'b0;
        end else begin
            if (take_hit) begin
                hit_valid_r  <= 1'b1;
                hit_number_r <= map_number;
                key_number   <= map_number;
            end else if (hit_if.hit_ack) begin
                hit_valid_r <= 1'b0;
            end
            invalid_pulse <= inval_ev;
            missed_pulse  <= miss_ev;
        end
    end

    assign hit_if.hit_valid  = hit_valid_r;
    assign hit_if.hit_number = hit_number_r;
endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: cycle table, directed corner sequences and
// randomized traffic, all checked against a run-length reference model.
module tb_key_event_decoder;
    import wam_key_pkg::*;

    localparam int D     = 4;
    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int NUM_W = 4;

    logic       clk = 1'b0;
    logic       reset, enable, key_down;
    logic [3:0] key;
    logic [3:0] key_number;
    logic       invalid_pulse, missed_pulse;

    key_event_decoder_if #(.NUM_W(NUM_W)) hif ();

    key_event_decoder #(
        .ROW_BITS(2), .COL_BITS(2), .ROWS(ROWS), .COLS(COLS),
        .NUM_W(NUM_W), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .key           (key),
        .key_down      (key_down),
        .hit_if        (hif),
        .key_number    (key_number),
        .invalid_pulse (invalid_pulse),
        .missed_pulse  (missed_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: synchronised samples arrive two edges late; a press is
    // qualified after D+1 consecutive identical down samples starting from idle,
    // and re-armed only after D+1 consecutive up samples.
    logic [3:0] ms1_key = '0, ms2_key = '0, rcode = '0;
    logic       ms1_down = 0, ms2_down = 0;
    bit         armed = 1;
    int         run = 0, rel = 0;
    logic       m_hv = 0, m_inv = 0, m_miss = 0;
    logic [3:0] m_hn = 4'hf, m_kn = 4'hf;

    task automatic model_edge(input logic r, input logic en, input logic [3:0] k,
                              input logic d, input logic a);
        logic [3:0] u_key;
        logic       u_down, ev, vld, take;
        int         row, col, num;
        u_key  = ms2_key;
        u_down = ms2_down;
        if (r) begin
            ms1_key = '0; ms2_key = '0; ms1_down = 0; ms2_down = 0;
            armed = 1; run = 0; rel = 0;
            m_hv = 0; m_hn = 4'hf; m_kn = 4'hf; m_inv = 0; m_miss = 0;
            return;
        end
        ms2_key = ms1_key; ms2_down = ms1_down;
        ms1_key = k;       ms1_down = d;
        ev = 0;
        if (!en) begin
            armed = 1; run = 0; rel = 0;
        end else if (armed) begin
            if (run == 0) begin
                if (u_down) begin run = 1; rcode = u_key; end
            end else if (u_down && u_key == rcode) begin
                run++;
                if (run == D + 1) begin ev = 1; armed = 0; run = 0; rel = 0; end
            end else begin
                run = 0;
            end
        end else begin
            if (rel == 0) begin
                if (!u_down) rel = 1;
            end else if (u_down) begin
                rel = 0;
            end else begin
                rel++;
                if (rel == D + 1) begin armed = 1; run = 0; rel = 0; end
            end
        end
        row  = int'(rcode) / 4;
        col  = int'(rcode) % 4;
        vld  = (row < ROWS) && (col < COLS);
        num  = row * COLS + col;
        take = ev && vld && (!m_hv || a);
        m_inv  = ev && !vld;
        m_miss = ev && vld && m_hv && !a;
        if (take) begin m_hv = 1; m_hn = 4'(num); m_kn = 4'(num); end
        else if (a) m_hv = 0;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [3:0] k,
                        input logic d, input logic a, input string nm);
        reset = r; enable = en; key = k; key_down = d; hif.hit_ack = a;
        @(posedge clk);
        model_edge(r, en, k, d, a);
        #1;
        n_vec++;
        if (hif.hit_valid !== m_hv || hif.hit_number !== m_hn || key_number !== m_kn ||
            invalid_pulse !== m_inv || missed_pulse !== m_miss) begin
            n_err++;
            $display("FAIL %s: got hv=%b hn=%0h kn=%0h inv=%b miss=%b expected hv=%b hn=%0h kn=%0h inv=%b miss=%b",
                     nm, hif.hit_valid, hif.hit_number, key_number, invalid_pulse, missed_pulse,
                     m_hv, m_hn, m_kn, m_inv, m_miss);
        end
    endtask

    typedef struct {
        logic       r, en, d, a;
        logic [3:0] k;
        logic       hv;
        logic [3:0] hn, kn;
        logic       inv, miss;
    } vec_t;

    function automatic vec_t mkv(logic r, logic en, logic [3:0] k, logic d, logic a,
                                 logic hv, logic [3:0] hn, logic [3:0] kn,
                                 logic inv, logic miss);
        vec_t v;
        v.r = r; v.en = en; v.k = k; v.d = d; v.a = a;
        v.hv = hv; v.hn = hn; v.kn = kn; v.inv = inv; v.miss = miss;
        return v;
    endfunction

    task automatic release_keys(input logic a0);
        for (int i = 0; i < 8; i++) step(0, 1, 4'h0, 0, (i == 0) ? a0 : 1'b0, "release");
    endtask

    vec_t tbl[$];
    logic seen;

    initial begin
        // Reset, then key 0110 held 12 cycles, then ack while still held.
        for (int i = 0; i < 3; i++) tbl.push_back(mkv(1, 1, 4'h6, 0, 0, 0, 4'hf, 4'hf, 0, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(mkv(0, 1, 4'h6, 1, 0, 0, 4'hf, 4'hf, 0, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(mkv(0, 1, 4'h6, 1, 0, 1, 4'h5, 4'h5, 0, 0));
        tbl.push_back(mkv(0, 1, 4'h6, 1, 1, 0, 4'h5, 4'h5, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mkv(0, 1, 4'h6, 1, 0, 0, 4'h5, 4'h5, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].en, tbl[i].k, tbl[i].d, tbl[i].a, "table_model");
            chk($sformatf("tbl%0d_hv", i), 8'(hif.hit_valid), 8'(tbl[i].hv));
            chk($sformatf("tbl%0d_hn", i), 8'(hif.hit_number), 8'(tbl[i].hn));
            chk($sformatf("tbl%0d_kn", i), 8'(key_number), 8'(tbl[i].kn));
            chk($sformatf("tbl%0d_pulses", i), 8'({invalid_pulse, missed_pulse}),
                8'({tbl[i].inv, tbl[i].miss}));
        end

        // Bouncing press never qualifies.
        release_keys(0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 4'h1, ((i / 2) % 2) == 0, 0, "bounce");
            seen = seen | hif.hit_valid | invalid_pulse | missed_pulse;
        end
        chk("bounce_no_event", 8'(seen), 8'd0);
        release_keys(0);

        // Off-grid code 0011.
        for (int i = 0; i < 7; i++) step(0, 1, 4'h3, 1, 0, "offgrid");
        chk("offgrid_inv", 8'(invalid_pulse), 8'd1);
        chk("offgrid_hv", 8'(hif.hit_valid), 8'd0);
        chk("offgrid_kn", 8'(key_number), 8'd5);
        step(0, 1, 4'h3, 1, 0, "offgrid");
        chk("offgrid_inv_one_cycle", 8'(invalid_pulse), 8'd0);
        release_keys(0);

        // Hit 3 left pending, then 8 is missed, then 8 replaces it with same-cycle ack.
        for (int i = 0; i < 7; i++) step(0, 1, 4'h4, 1, 0, "hit3");
        chk("hit3_hv", 8'(hif.hit_valid), 8'd1);
        chk("hit3_hn", 8'(hif.hit_number), 8'd3);
        release_keys(0);
        for (int i = 0; i < 7; i++) step(0, 1, 4'ha, 1, 0, "miss8");
        chk("miss_pulse", 8'(missed_pulse), 8'd1);
        chk("miss_hn_kept", 8'(hif.hit_number), 8'd3);
        chk("miss_kn_kept", 8'(key_number), 8'd3);
        step(0, 1, 4'ha, 1, 0, "miss8");
        chk("miss_one_cycle", 8'(missed_pulse), 8'd0);
        release_keys(0);
        for (int i = 0; i < 7; i++) step(0, 1, 4'ha, 1, i == 6, "ack_event");
        chk("ack_event_hv", 8'(hif.hit_valid), 8'd1);
        chk("ack_event_hn", 8'(hif.hit_number), 8'd8);
        chk("ack_event_miss", 8'(missed_pulse), 8'd0);
        release_keys(1);
        chk("acked_hv", 8'(hif.hit_valid), 8'd0);

        // Reset in the middle of a press debounce.
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(i == 4, 1, 4'h6, 1, 0, "reset_mid");
            seen = seen | hif.hit_valid;
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 4'h6, 0, 0, "reset_mid");
            seen = seen | hif.hit_valid;
        end
        chk("reset_mid_no_event", 8'(seen), 8'd0);
        chk("reset_mid_kn", 8'(key_number), 8'hf);
        for (int i = 0; i < 7; i++) step(0, 1, 4'h6, 1, 0, "repress");
        chk("repress_hv", 8'(hif.hit_valid), 8'd1);
        chk("repress_hn", 8'(hif.hit_number), 8'd5);
        release_keys(1);

        // Enable dropped for one cycle during the press debounce restarts it.
        for (int i = 0; i < 10; i++) begin
            step(0, i != 4, 4'h5, 1, 0, "enable_drop");
            if (i == 6) chk("enable_drop_no_event", 8'(hif.hit_valid), 8'd0);
        end
        chk("enable_drop_late_hv", 8'(hif.hit_valid), 8'd1);
        chk("enable_drop_late_hn", 8'(hif.hit_number), 8'd4);
        release_keys(1);

        // Randomized traffic against the model.
        begin
            int span = 0;
            logic [3:0] rkey = '0;
            logic rdown = 0;
            for (int i = 0; i < 2000; i++) begin
                if (span == 0) begin
                    span  = $urandom_range(1, 12);
                    rkey  = 4'($urandom_range(0, 15));
                    rdown = ($urandom_range(0, 3) != 0);
                end
                span--;
                step($urandom_range(0, 299) == 0, $urandom_range(0, 49) != 0,
                     rkey, rdown, $urandom_range(0, 3) == 0, "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
